// File: rtl/irq_controller.sv
// Interrupt controller: synchronizes and edge-detects external lines, latches pending
// events and presents the highest-priority enabled one over a req/ack/done handshake.
module irq_controller #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = 3
) (
    input  logic               Reset,
    input  logic               Clock,
    input  logic [NUM_IRQ-1:0] IrqIn,
    input  logic [NUM_IRQ-1:0] IrqMask,
    input  logic               IrqAck,
    input  logic               IrqDone,
    output logic               IrqReq,
    output logic [ID_W-1:0]    IrqId,
    output logic [NUM_IRQ-1:0] Pending
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] sync1_q, sync1_d;
    logic [NUM_IRQ-1:0] sync2_q, sync2_d;
    logic [NUM_IRQ-1:0] prev_q, prev_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               req_q, req_d;
    logic [ID_W-1:0]    id_q, id_d;

    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [ID_W-1:0]    winner;

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d  = IrqIn;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        edge_det = sync2_q & ~prev_q;
        eligible = pending_q & IrqMask;

        // Descending scan so the lowest set index is the last one written.
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end

        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = (state_q == REQ) && IrqAck && (id_q == ID_W'(i));
        end

        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    id_d    = winner;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Request is frozen until Ack; mask changes and new higher-priority
                // events are deliberately ignored here.
                if (IrqAck) begin
                    req_d   = 1'b0;
                    state_d = SERVICE;
                end
            end
            SERVICE: begin
                if (IrqDone) state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A fresh edge in the Ack cycle must survive, so the set term is applied last.
        pending_d = (pending_q & ~ack_clr) | edge_det;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
            req_q     <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            id_q      <= id_d;
        end
    end

    assign IrqReq  = req_q;
    assign IrqId   = id_q;
    assign Pending = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed handshake scenarios plus randomized
// traffic, all compared every cycle against a sample-history reference model.
module tb_irq_controller;

    localparam int N  = 4;
    localparam int IW = 3;

    logic          Reset;
    logic          Clock;
    logic [N-1:0]  IrqIn;
    logic [N-1:0]  IrqMask;
    logic          IrqAck;
    logic          IrqDone;
    logic          IrqReq;
    logic [IW-1:0] IrqId;
    logic [N-1:0]  Pending;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .Reset   (Reset),
        .Clock   (Clock),
        .IrqIn   (IrqIn),
        .IrqMask (IrqMask),
        .IrqAck  (IrqAck),
        .IrqDone (IrqDone),
        .IrqReq  (IrqReq),
        .IrqId   (IrqId),
        .Pending (Pending)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: the last three clock samples of each line, the set of pending
    // events and which handshake phase the CPU is in (0 idle, 1 requested, 2 serving).
    typedef struct packed {
        logic [N-1:0]  s0;
        logic [N-1:0]  s1;
        logic [N-1:0]  s2;
        logic [N-1:0]  pend;
        logic          req;
        logic [IW-1:0] id;
        logic [1:0]    phase;
    } model_t;

    model_t m_q;

    function automatic model_t model_next(model_t s, logic [N-1:0] in_v, logic [N-1:0] mask,
                                          logic ack, logic done);
        model_t       n  = s;
        logic [N-1:0] ev = s.s1 & ~s.s2;
        int           lowest = -1;
        n.s2 = s.s1;
        n.s1 = s.s0;
        n.s0 = in_v;
        for (int i = 0; i < N; i++) begin
            if (lowest < 0 && s.pend[i] && mask[i]) lowest = i;
        end
        if (s.phase == 2'd0 && lowest >= 0) begin
            n.id    = IW'(lowest);
            n.req   = 1'b1;
            n.phase = 2'd1;
        end else if (s.phase == 2'd1 && ack) begin
            n.pend[s.id] = 1'b0;
            n.req        = 1'b0;
            n.phase      = 2'd2;
        end else if (s.phase == 2'd2 && done) begin
            n.phase = 2'd0;
        end
        n.pend = n.pend | ev;
        return n;
    endfunction

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) m_q <= '0;
        else        m_q <= model_next(m_q, IrqIn, IrqMask, IrqAck, IrqDone);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge Clock) begin
        check("model_req", 32'(IrqReq), 32'(m_q.req));
        check("model_pending", 32'(Pending), 32'(m_q.pend));
        if (m_q.req) check("model_id", 32'(IrqId), 32'(m_q.id));
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic pulse_ack();
        IrqAck = 1'b1;
        step(1);
        IrqAck = 1'b0;
    endtask

    task automatic pulse_done();
        IrqDone = 1'b1;
        step(1);
        IrqDone = 1'b0;
    endtask

    initial begin
        Reset   = 1'b0;
        IrqIn   = '0;
        IrqMask = 4'b1111;
        IrqAck  = 1'b0;
        IrqDone = 1'b0;
        step(3);
        check("reset_req", 32'(IrqReq), 32'd0);
        check("reset_id", 32'(IrqId), 32'd0);
        check("reset_pending", 32'(Pending), 32'd0);
        Reset = 1'b1;
        step(4);

        // Single event on line 2.
        IrqIn = 4'b0100;
        step(3);
        check("single_req_early", 32'(IrqReq), 32'd0);
        check("single_pend", 32'(Pending), 32'b0100);
        step(1);
        check("single_req", 32'(IrqReq), 32'd1);
        check("single_id", 32'(IrqId), 32'd2);
        pulse_ack();
        IrqIn = '0;
        check("single_ack_req", 32'(IrqReq), 32'd0);
        check("single_ack_pend", 32'(Pending), 32'd0);
        pulse_done();
        step(5);
        check("single_no_more", 32'(IrqReq), 32'd0);

        // Priority: lines 3 and 1 together.
        IrqIn = 4'b1010;
        step(4);
        check("prio_req", 32'(IrqReq), 32'd1);
        check("prio_id_first", 32'(IrqId), 32'd1);
        check("prio_pend", 32'(Pending), 32'b1010);
        pulse_ack();
        check("prio_ack_pend", 32'(Pending), 32'b1000);
        pulse_done();
        check("prio_gap", 32'(IrqReq), 32'd0);
        step(1);
        check("prio_req2", 32'(IrqReq), 32'd1);
        check("prio_id_second", 32'(IrqId), 32'd3);
        pulse_ack();
        pulse_done();
        IrqIn = '0;
        step(4);

        // Masking line 0.
        IrqMask = 4'b1110;
        IrqIn   = 4'b0001;
        step(6);
        check("mask_pend", 32'(Pending), 32'b0001);
        check("mask_no_req", 32'(IrqReq), 32'd0);
        IrqMask = 4'b1111;
        step(1);
        check("unmask_req", 32'(IrqReq), 32'd1);
        check("unmask_id", 32'(IrqId), 32'd0);
        pulse_ack();
        pulse_done();
        IrqIn = '0;
        step(4);

        // Set/clear collision on line 1.
        IrqIn = 4'b0010;
        step(4);
        check("coll_req", 32'(IrqReq), 32'd1);
        check("coll_id", 32'(IrqId), 32'd1);
        IrqIn = '0;
        step(3);
        IrqIn = 4'b0010;
        step(2);
        pulse_ack();
        check("coll_ack_req", 32'(IrqReq), 32'd0);
        check("coll_set_wins", 32'(Pending), 32'b0010);
        pulse_done();
        step(1);
        check("coll_rereq", 32'(IrqReq), 32'd1);
        check("coll_reid", 32'(IrqId), 32'd1);
        pulse_ack();
        pulse_done();
        IrqIn = '0;
        step(4);

        // Stability of a held request.
        IrqIn = 4'b0100;
        step(4);
        check("stab_req", 32'(IrqReq), 32'd1);
        IrqMask = 4'b1011;
        IrqIn   = 4'b0101;
        step(6);
        check("stab_hold_req", 32'(IrqReq), 32'd1);
        check("stab_hold_id", 32'(IrqId), 32'd2);
        check("stab_pend", 32'(Pending), 32'b0101);
        pulse_ack();
        check("stab_ack_pend", 32'(Pending), 32'b0001);
        IrqMask = 4'b1111;
        pulse_done();
        step(1);
        check("stab_next_id", 32'(IrqId), 32'd0);
        pulse_ack();
        pulse_done();
        IrqIn = '0;
        step(4);
        pulse_ack();
        check("idle_ack_req", 32'(IrqReq), 32'd0);
        check("idle_ack_pend", 32'(Pending), 32'd0);
        pulse_done();
        step(2);
        check("idle_quiet", 32'(IrqReq), 32'd0);

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) IrqIn[b] = ~IrqIn[b];
            end
            if ($urandom_range(0, 15) == 0) IrqMask = N'($urandom);
            IrqAck  = ($urandom_range(0, 2) == 0);
            IrqDone = ($urandom_range(0, 2) == 0);
            step(1);
        end
        IrqAck  = 1'b0;
        IrqDone = 1'b0;
        IrqMask = 4'b1111;

        // Asynchronous reset in the middle of a request.
        Reset = 1'b0;
        step(2);
        Reset = 1'b1;
        IrqIn = 4'b0001;
        step(4);
        check("rst_pre_req", 32'(IrqReq), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("rst_async_req", 32'(IrqReq), 32'd0);
        check("rst_async_id", 32'(IrqId), 32'd0);
        check("rst_async_pend", 32'(Pending), 32'd0);
        step(2);
        Reset = 1'b1;
        step(3);
        check("rst_rel_early", 32'(IrqReq), 32'd0);
        step(1);
        check("rst_rel_req", 32'(IrqReq), 32'd1);
        check("rst_rel_id", 32'(IrqId), 32'd0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
